serial_subtractor: RTL

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/sub_pkg.sv | 14 +
 rtl/fullsubtractor.sv | 17 +
 rtl/serial_subtractor.sv | 119 +++++++++++
 3 files changed

// File: rtl/sub_pkg.sv
// Shared definitions for the bit-serial subtractor.
//   state_e      : control states (idle, shifting, result presentation)
//   DefaultWidth : default operand/result width in bits
package sub_pkg;

  localparam int unsigned DefaultWidth = 8;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

endpackage

// File: rtl/fullsubtractor.sv
// One-bit full-subtractor cell: computes A - B - Bin.
//   A, B : operand bits
//   Bin  : borrow in
//   Diff : difference bit
//   Bout : borrow out
module fullsubtractor (
  input  logic A,
  input  logic B,
  input  logic Bin,
  output logic Diff,
  output logic Bout
);

  assign Diff = A ^ B ^ Bin;
  assign Bout = (~A & B) | (~(A ^ B) & Bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: Diff = A - B (mod 2^WIDTH), LSB first, one bit per clock.
//   clk, rst_n : clock and asynchronous active-low reset
//   start      : begin an operation (accepted only when idle)
//   A, B       : minuend / subtrahend, captured on the accepting edge
//   busy       : high while an operation is in progress (RUN or DONE)
//   done       : one-cycle pulse when Diff/Borrow carry a fresh result
//   Diff       : last completed difference
//   Borrow     : last completed final borrow (1 when A < B)
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             Borrow
);

  // One extra bit so the counter can hold WIDTH without wrapping.
  localparam int unsigned    CntW    = $clog2(WIDTH) + 1;
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bff_q, bff_d;
  logic             borrow_q, borrow_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  logic cell_diff;
  logic cell_bout;

  fullsubtractor u_cell (
    .A    (a_q[0]),
    .B    (b_q[0]),
    .Bin  (bff_q),
    .Diff (cell_diff),
    .Bout (cell_bout)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    bff_d    = bff_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          a_d     = A;
          b_d     = B;
          bff_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      StRun: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        // Result fills from the MSB side so the LSB lands at bit 0 after WIDTH shifts.
        res_d = {cell_diff, res_q[WIDTH-1:1]};
        bff_d = cell_bout;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == LastBit) begin
          state_d  = StDone;
          // Publish the fully shifted result, including this cycle's bit.
          diff_d   = res_d;
          borrow_d = cell_bout;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      bff_q    <= 1'b0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      bff_q    <= bff_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
    end
  end

  assign busy   = (state_q != StIdle);
  assign done   = (state_q == StDone);
  assign Diff   = diff_q;
  assign Borrow = borrow_q;

endmodule
